// File: rtl/uart_multi_dac_loader_pkg.sv
// Shared types and constants for the UART-to-DAC loader: receiver FSM states,
// the default realignment marker and the sample byte-count helper.
package uart_dac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_HOLD
   } rx_state_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   function automatic int unsigned bytes_per_sample(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/uart_multi_dac_loader_if.sv
// Byte-level link between the UART receiver core (master) and the frame
// assembler (slave); abort flows back to the receiver.
interface uart_multi_dac_loader_if;

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;
   logic       abort;

   modport master (
      output rx_byte,
      output byte_valid,
      output frame_err,
      input  abort
   );

   modport slave (
      input  rx_byte,
      input  byte_valid,
      input  frame_err,
      output abort
   );

endinterface

// File: rtl/uart_multi_dac_loader_rx_core.sv
// 8N1 UART receiver: RX synchroniser, START/DATA/STOP/HOLD bit FSM, and
// single-cycle byte_valid / frame_err strobes aligned to the stop-bit sample.
module uart_rx_core
   import uart_dac_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned HOLD_DELAY   = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           rx_serial_i,
   uart_multi_dac_loader_if.master        rx_if
);

   localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
   localparam int unsigned HOLD_CYC = (HOLD_DELAY == 0) ? 1 : HOLD_DELAY;
   localparam int unsigned HW       = $clog2(HOLD_CYC + 1);

   localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   rx_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           rx_meta_q, rx_sync_q;
   logic           valid_c, err_c;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         hold_q    <= '0;
      end else begin
         rx_meta_q <= rx_serial_i;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         hold_q    <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      hold_d  = hold_q;
      valid_c = 1'b0;
      err_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            hold_d = '0;
            if (!rx_sync_q) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               hold_d  = '0;
               state_d = ST_HOLD;
               valid_c = rx_sync_q;
               err_c   = ~rx_sync_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = ST_IDLE;
            else                     hold_d  = hold_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort wins over everything, including a stop sample in the same cycle.
      if (rx_if.abort) begin
         state_d = ST_IDLE;
         valid_c = 1'b0;
         err_c   = 1'b0;
      end
   end

   assign rx_if.rx_byte    = shift_q;
   assign rx_if.byte_valid = valid_c;
   assign rx_if.frame_err  = err_c;

endmodule

// File: rtl/uart_multi_dac_loader.sv
// UART-to-DAC loader: enable latch, sample assembly into shadow registers and
// atomic commit of all channels to the DAC buses.
module uart_multi_dac_loader
   import uart_dac_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned HOLD_DELAY   = 1,
   parameter bit          SYNC_EN      = 1'b1,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset_n,
   input  logic                         i_Rx_Serial,
   input  logic                         i_Enable,
   output logic [NUM_CH*DATA_WIDTH-1:0] o_Data,
   output logic [NUM_CH-1:0]            o_Ch_Toggle,
   output logic                         o_Update,
   output logic                         o_Frame_Error,
   output logic                         o_Rx_Enabled
);

   localparam int unsigned BPS = bytes_per_sample(DATA_WIDTH);
   localparam int unsigned BIW = (BPS > 1) ? $clog2(BPS) : 1;
   localparam int unsigned CIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned TW  = NUM_CH * DATA_WIDTH;
   localparam int unsigned OW  = $clog2(TW);

   localparam logic [BIW-1:0] BYTE_LAST = BIW'(BPS - 1);
   localparam logic [CIW-1:0] CH_LAST   = CIW'(NUM_CH - 1);

   logic           en_meta_q, en_sync_q, en_prev_q;
   logic           en_latch_q, en_latch_d;
   logic [CIW-1:0] ch_idx_q, ch_idx_d;
   logic [BIW-1:0] byte_idx_q, byte_idx_d;
   logic [TW-1:0]  shadow_q, shadow_d;
   logic [TW-1:0]  data_q, data_d;
   logic [NUM_CH-1:0] toggle_q, toggle_d;
   logic           update_q, update_d;
   logic           frame_err_q, frame_err_d;
   logic [OW-1:0]  wr_off;

   uart_multi_dac_loader_if rx_if ();

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .HOLD_DELAY   (HOLD_DELAY)
   ) u_rx_core (
      .clk_i       (i_Clock),
      .rst_ni      (i_Reset_n),
      .rx_serial_i (i_Rx_Serial),
      .rx_if       (rx_if.master)
   );

   assign rx_if.abort = ~en_latch_q;

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         en_meta_q   <= 1'b0;
         en_sync_q   <= 1'b0;
         en_prev_q   <= 1'b0;
         en_latch_q  <= 1'b0;
         ch_idx_q    <= '0;
         byte_idx_q  <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         toggle_q    <= '0;
         update_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         en_meta_q   <= i_Enable;
         en_sync_q   <= en_meta_q;
         en_prev_q   <= en_sync_q;
         en_latch_q  <= en_latch_d;
         ch_idx_q    <= ch_idx_d;
         byte_idx_q  <= byte_idx_d;
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         toggle_q    <= toggle_d;
         update_q    <= update_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      en_latch_d  = en_latch_q ^ (en_sync_q & ~en_prev_q);
      ch_idx_d    = ch_idx_q;
      byte_idx_d  = byte_idx_q;
      shadow_d    = shadow_q;
      data_d      = data_q;
      toggle_d    = toggle_q;
      update_d    = 1'b0;
      frame_err_d = 1'b0;
      wr_off      = OW'(ch_idx_q) * OW'(DATA_WIDTH) + OW'({byte_idx_q, 3'b000});

      if (!en_latch_q) begin
         ch_idx_d   = '0;
         byte_idx_d = '0;
      end else if (rx_if.frame_err) begin
         frame_err_d = 1'b1;
         ch_idx_d    = '0;
         byte_idx_d  = '0;
      end else if (rx_if.byte_valid) begin
         if (SYNC_EN && (rx_if.rx_byte == SYNC_BYTE)) begin
            ch_idx_d   = '0;
            byte_idx_d = '0;
         end else begin
            shadow_d[wr_off +: 8] = rx_if.rx_byte;
            if (byte_idx_q == BYTE_LAST) begin
               byte_idx_d = '0;
               // Commit copies shadow_d so the final byte lands in the same cycle.
               if (ch_idx_q == CH_LAST) begin
                  ch_idx_d = '0;
                  data_d   = shadow_d;
                  toggle_d = ~toggle_q;
                  update_d = 1'b1;
               end else begin
                  ch_idx_d = ch_idx_q + 1'b1;
               end
            end else begin
               byte_idx_d = byte_idx_q + 1'b1;
            end
         end
      end
   end

   assign o_Data        = data_q;
   assign o_Ch_Toggle   = toggle_q;
   assign o_Update      = update_q;
   assign o_Frame_Error = frame_err_q;
   assign o_Rx_Enabled  = en_latch_q;

endmodule

// File: tb/tb_uart_multi_dac_loader.sv
// Scoreboard bench: two loader instances (8-bit x2 and 16-bit x3) fed with
// serial bytes; expected commits are queued at send time and checked on o_Update.
module tb_uart_multi_dac_loader;

   localparam int CPB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, rx_a, rx_b;
   logic [15:0] data_a;
   logic [1:0]  tog_a;
   logic        upd_a, ferr_a, ren_a;
   logic [47:0] data_b;
   logic [2:0]  tog_b;
   logic        upd_b, ferr_b, ren_b;

   int n_tot = 0;
   int n_bad = 0;
   int upd_cnt_a = 0, upd_cnt_b = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
   logic [63:0] sb_a[$];
   logic [63:0] sb_b[$];
   logic [1:0]  tog_exp_a = '0;
   logic [2:0]  tog_exp_b = '0;

   uart_multi_dac_loader #(
      .CLKS_PER_BIT (CPB), .DATA_WIDTH (8), .NUM_CH (2),
      .HOLD_DELAY (1), .SYNC_EN (1), .SYNC_BYTE (8'hA5)
   ) dut_a (
      .i_Clock (clk), .i_Reset_n (rst_n), .i_Rx_Serial (rx_a), .i_Enable (en),
      .o_Data (data_a), .o_Ch_Toggle (tog_a), .o_Update (upd_a),
      .o_Frame_Error (ferr_a), .o_Rx_Enabled (ren_a)
   );

   uart_multi_dac_loader #(
      .CLKS_PER_BIT (CPB), .DATA_WIDTH (16), .NUM_CH (3),
      .HOLD_DELAY (0), .SYNC_EN (1), .SYNC_BYTE (8'hA5)
   ) dut_b (
      .i_Clock (clk), .i_Reset_n (rst_n), .i_Rx_Serial (rx_b), .i_Enable (en),
      .o_Data (data_b), .o_Ch_Toggle (tog_b), .o_Update (upd_b),
      .o_Frame_Error (ferr_b), .o_Rx_Enabled (ren_b)
   );

   // Byte-level view of instance A's strobes.
   uart_multi_dac_loader_if mon_if ();
   assign mon_if.rx_byte    = data_a[7:0];
   assign mon_if.byte_valid = upd_a;
   assign mon_if.frame_err  = ferr_a;
   assign mon_if.abort      = ~ren_a;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_line(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      drive_line(sel, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive_line(sel, b[i]);
         repeat (CPB) @(negedge clk);
      end
      drive_line(sel, stop_ok);
      repeat (CPB) @(negedge clk);
      drive_line(sel, 1'b1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic expect_a(input logic [15:0] d);
      tog_exp_a = ~tog_exp_a;
      sb_a.push_back(64'({tog_exp_a, d}));
   endtask

   task automatic expect_b(input logic [47:0] d);
      tog_exp_b = ~tog_exp_b;
      sb_b.push_back(64'({tog_exp_b, d}));
   endtask

   task automatic press_enable();
      @(negedge clk);
      en = 1'b1;
      repeat (4) @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_if.frame_err) ferr_cnt_a++;
      if (ferr_b) ferr_cnt_b++;
      if (mon_if.byte_valid) begin
         upd_cnt_a++;
         if (sb_a.size() == 0) chk("upd_a_unexpected", 64'(upd_a), 64'(0));
         else                  chk("commit_a", 64'({tog_a, data_a}), sb_a.pop_front());
      end
      if (upd_b) begin
         upd_cnt_b++;
         if (sb_b.size() == 0) chk("upd_b_unexpected", 64'(upd_b), 64'(0));
         else                  chk("commit_b", 64'({tog_b, data_b}), sb_b.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data_a", 64'(data_a), 64'(0));
      chk("rst_tog_a", 64'(tog_a), 64'(0));
      chk("rst_upd_a", 64'(upd_a), 64'(0));
      chk("rst_ferr_a", 64'(ferr_a), 64'(0));
      chk("rst_ren_a", 64'(ren_a), 64'(0));
      chk("rst_data_b", 64'(data_b), 64'(0));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      press_enable();
      chk("ren_a_on", 64'(ren_a), 64'(1));
      chk("ren_b_on", 64'(ren_b), 64'(1));

      // 8-bit, two channels
      send_byte(0, 8'h12, 1);
      chk("t1_no_partial", 64'(upd_cnt_a), 64'(0));
      expect_a(16'h3412);
      send_byte(0, 8'h34, 1);
      chk("t1_data", 64'(data_a), 64'h3412);
      chk("t1_tog", 64'(tog_a), 64'(2'b11));

      // 16-bit, three channels, LSB byte first
      for (int i = 1; i <= 5; i++) send_byte(1, 8'(i), 1);
      chk("t2_no_early_upd", 64'(upd_cnt_b), 64'(0));
      expect_b(48'h0605_0403_0201);
      send_byte(1, 8'h06, 1);
      chk("t2_data", 64'(data_b), 64'h0605_0403_0201);

      // sync byte realigns
      send_byte(0, 8'h11, 1);
      send_byte(0, 8'hA5, 1);
      send_byte(0, 8'h22, 1);
      expect_a(16'h3322);
      send_byte(0, 8'h33, 1);
      chk("t3_data", 64'(data_a), 64'h3322);

      // framing error
      send_byte(0, 8'h55, 0);
      chk("t4_ferr_cnt", 64'(ferr_cnt_a), 64'(1));
      chk("t4_data_hold", 64'(data_a), 64'h3322);
      send_byte(0, 8'h66, 1);
      expect_a(16'h7766);
      send_byte(0, 8'h77, 1);
      chk("t4_data", 64'(data_a), 64'h7766);

      send_byte(1, 8'h0A, 1);
      send_byte(1, 8'h0B, 0);
      chk("t4b_ferr_cnt", 64'(ferr_cnt_b), 64'(1));
      for (int i = 0; i < 5; i++) send_byte(1, 8'(8'h10 + i), 1);
      expect_b(48'h1514_1312_1110);
      send_byte(1, 8'h15, 1);

      // disable mid-byte with a partial frame pending
      send_byte(0, 8'h5A, 1);
      fork
         send_byte(0, 8'h99, 1);
         begin
            repeat (40) @(negedge clk);
            press_enable();
         end
      join
      chk("t5_ren_off", 64'(ren_a), 64'(0));
      send_byte(0, 8'h01, 1);
      send_byte(0, 8'h02, 1);
      chk("t5_data_kept", 64'(data_a), 64'h7766);
      press_enable();
      chk("t5_ren_on", 64'(ren_a), 64'(1));
      send_byte(0, 8'h44, 1);
      expect_a(16'h8844);
      send_byte(0, 8'h88, 1);
      chk("t5_data", 64'(data_a), 64'h8844);

      // short low glitch on the line
      @(negedge clk);
      rx_a = 1'b0;
      repeat (2) @(negedge clk);
      rx_a = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      chk("t6_no_ferr", 64'(ferr_cnt_a), 64'(1));
      chk("t6_no_upd", 64'(upd_cnt_a), 64'(4));
      send_byte(0, 8'hC3, 1);
      expect_a(16'h3CC3);
      send_byte(0, 8'h3C, 1);
      chk("t6_data", 64'(data_a), 64'h3CC3);

      repeat (10) @(negedge clk);
      chk("sb_a_left", 64'(sb_a.size()), 64'(0));
      chk("sb_b_left", 64'(sb_b.size()), 64'(0));
      chk("upd_cnt_a", 64'(upd_cnt_a), 64'(5));
      chk("upd_cnt_b", 64'(upd_cnt_b), 64'(2));
      chk("ferr_cnt_b", 64'(ferr_cnt_b), 64'(1));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_multi_dac_loader.md
# uart_multi_dac_loader

Parametrised UART-to-DAC loader: receives 8N1 serial bytes, assembles DATA_WIDTH-bit samples for NUM_CH channels, and drives parallel DAC buses. Successor to the fixed two-channel 8-bit I/Q loader, with these additions:
- wider samples
- arbitrary channel count
- double-buffered atomic update of all channels
- sync-byte frame realignment
- framing-error detection

Sits between the host UART pin and the DAC output pins.

## Interface
Parameters:
- CLKS_PER_BIT, 10: clock cycles per UART bit; minimum 4.
- DATA_WIDTH, 8: sample width; legal values 8 or 16. Multi-byte samples are sent LSB byte first.
- NUM_CH, 2: number of DAC channels, 1..8. Channel 0 is received first.
- HOLD_DELAY, 1: idle cycles after each byte; 0 is legal.
- SYNC_EN, 1: enables sync-byte realignment.
- SYNC_BYTE, 8'hA5: realignment marker.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_Rx_Serial  in  1  UART RX line, idle high. Asynchronous to i_Clock.
- i_Enable  in  1  receive-enable button, asynchronous. A rising edge toggles the enable latch.
- o_Data  out  NUM_CH*DATA_WIDTH  DAC buses, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_Ch_Toggle  out  NUM_CH  per-channel activity bit. Inverts whenever that channel's output is updated.
- o_Update  out  1  one-cycle pulse when o_Data is loaded.
- o_Frame_Error  out  1  one-cycle pulse when a stop bit is sampled low.
- o_Rx_Enabled  out  1  current state of the enable latch.

## Operation
- **Synchronisers:** i_Rx_Serial and i_Enable each pass through a 2-flop synchroniser; both reset to 1/0 respectively. The enable latch toggles on the synchronised rising edge of i_Enable.
- **States:** IDLE, START, DATA, STOP, HOLD. The bit counter is $clog2(CLKS_PER_BIT) wide.
- **IDLE:** clears the bit counter and bit index. Goes to START when the latch is set and the synchronised RX line is 0.
- **START:** at count (CLKS_PER_BIT-1)/2, samples RX.
  - Low: clear counter, go to DATA.
  - High: glitch, return to IDLE.
- **DATA:** samples at count CLKS_PER_BIT-1, 8 bits LSB first, then goes to STOP.
- **STOP:** samples at count CLKS_PER_BIT-1.
  - High: byte accepted.
  - Low: o_Frame_Error pulses, the byte is discarded, channel and byte indices reset to 0, and the shadow register is left as is. Either way, go to HOLD.
- **HOLD:** waits HOLD_DELAY cycles, then returns to IDLE. With HOLD_DELAY=0, HOLD lasts exactly 1 cycle.
- **Sync byte:** when SYNC_EN=1 and an accepted byte equals SYNC_BYTE, it is not stored and the channel and byte indices reset to 0. Consequence: payload bytes equal to SYNC_BYTE cannot be sent in this mode.
- **Byte assembly:** other accepted bytes are written into shadow[ch_idx] at byte byte_idx. byte_idx wraps at DATA_WIDTH/8; ch_idx then advances and wraps at NUM_CH.
- **Atomic commit:** when the final byte of channel NUM_CH-1 is accepted:
  - the whole shadow copies to o_Data,
  - all o_Ch_Toggle bits invert,
  - o_Update pulses.
  
  Partial frames never reach o_Data.
- **Disable mid-byte:** when the enable latch is cleared, the FSM returns to IDLE on the next cycle, indices reset to 0, and any partial frame is discarded. o_Data holds its last value.
- **Reset values:** o_Data=0, o_Ch_Toggle=0, o_Update=0, o_Frame_Error=0, o_Rx_Enabled=0, FSM in IDLE, indices 0, shadow 0.

## Timing
- **Start detection:** from the RX falling edge at the pin to START entry is 3 cycles (2 synchroniser cycles + 1).
- **Commit latency:** o_Data, o_Ch_Toggle and o_Update all change on the cycle after the final stop-bit sample.
- **o_Frame_Error:** asserted on the cycle after the failing stop sample.
- **Byte period:** one byte occupies 1 + ((CLKS_PER_BIT-1)/2 + 1) + 9*CLKS_PER_BIT + max(HOLD_DELAY,1) cycles of FSM time. A host must send at the nominal baud with at least one stop bit.
- **Enable toggle during a commit cycle:** the commit completes and the latch change takes effect on the following cycle.
- **Reset mid-operation:** asynchronous assertion forces reset values immediately. Deassertion is sampled synchronously by the design's reset synchroniser upstream.

## Structure
- Package uart_dac_pkg holds:
  - the state enum (IDLE..HOLD),
  - the default SYNC_BYTE constant,
  - a function returning bytes-per-sample from DATA_WIDTH.
- Sub-module uart_rx_core contains the synchronisers, the START/DATA/STOP/HOLD FSM and the bit counter. Its outputs are:
  - byte[7:0],
  - byte_valid pulse,
  - frame_err pulse,
  - an abort input driven by the enable latch.
- The top level contains the enable latch, the indices, the shadow registers, the commit logic and the sync-byte compare.

## Test plan
1. DATA_WIDTH=8, NUM_CH=2, send 0x12, 0x34 → o_Data=0x3412 one cycle after the second stop sample. o_Update pulses once and o_Ch_Toggle=2'b11.
2. DATA_WIDTH=16, NUM_CH=3, send 6 bytes 01 02 03 04 05 06 → ch0=0x0201, ch1=0x0403, ch2=0x0605. No o_Update occurs before the 6th byte.
3. Send 0x11, then SYNC 0xA5, then 0x22, 0x33 → o_Data=0x3322. 0x11 is never visible on o_Data.
4. Send a byte with its stop bit driven low → o_Frame_Error pulses and o_Data is unchanged. The next two good bytes commit as channel 0 and channel 1.
5. Press i_Enable a second time mid-byte → o_Rx_Enabled=0 and the FSM returns to IDLE. RX traffic is then ignored until the next press. o_Data keeps its prior value.
6. A 0.3-bit low glitch on RX → START aborts back to IDLE with no byte and no error.
